wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register outputs. It contains the 32x32 MIPS general-purpose register file.
- Selects the writeback data, either memory load data or the ALU result.
- Commits the selected data to the register file on the clock edge.
- Serves two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Keeps a retired-writeback counter for debug and performance checks.

---
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage register file: WB mux, 32x32 GPR storage with r0 hardwired to zero,
// two bypassed combinational read ports, an unbypassed debug port and a commit counter.
module wb_rd_port #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int AW       = 5
) (
  input  logic [AW-1:0]                    addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic                             byp_en,
  input  logic [AW-1:0]                    byp_addr,
  input  logic [DATA_W-1:0]                byp_data,
  output logic [DATA_W-1:0]                data
);
  // r0 check comes first so a write aimed at r0 can never leak through the bypass
  always_comb begin
    data = '0;
    if (addr == '0)                          data = '0;
    else if (byp_en && (byp_addr == addr))   data = byp_data;
    else                                     data = regs[addr];
  end
endmodule

module wb_regfile #(
  parameter int  NUM_REGS = 32,
  parameter int  DATA_W   = 32,
  parameter int  CNT_W    = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [AW-1:0]     write_reg_in,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count
);
  localparam int NPORTS = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            commit;
  logic                            byp_en;
  logic [NPORTS-1:0][AW-1:0]       rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0]   rd_data;

  assign wb_data = MemToReg_in ? read_data_in : alu_result_in;
  assign commit  = RegWrite_in && (write_reg_in != '0) && !reset;
  // bypass is held off during reset so reads see storage only
  assign byp_en  = RegWrite_in && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '0;
      wb_count <= '0;
    end else if (commit) begin
      regs[write_reg_in] <= wb_data;
      wb_count           <= wb_count + CNT_W'(1);
    end
  end

  assign rd_addr = {rt_addr, rs_addr};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    wb_rd_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .AW(AW)) u_port (
      .addr     (rd_addr[p]),
      .regs     (regs),
      .byp_en   (byp_en),
      .byp_addr (write_reg_in),
      .byp_data (wb_data),
      .data     (rd_data[p])
    );
  end

  assign rs_data  = rd_data[0];
  assign rt_data  = rd_data[1];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus random bench for wb_regfile against an array-based reference model;
// a second narrow-counter instance exposes the counter wrap quickly.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset, MemToReg_in, RegWrite_in;
  logic [31:0] read_data_in, alu_result_in;
  logic [4:0]  write_reg_in, rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wb_data, wb_count;
  logic [31:0] rs_data4, rt_data4, dbg_data4, wb_data4;
  logic [3:0]  wb_count4;

  logic [31:0] model [32];
  int unsigned cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
    .rs_data(rs_data), .rt_data(rt_data), .dbg_data(dbg_data), .wb_data(wb_data),
    .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in), .write_reg_in(write_reg_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
    .rs_data(rs_data4), .rt_data(rt_data4), .dbg_data(dbg_data4), .wb_data(wb_data4),
    .wb_count(wb_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, optionally check every output against the model, then clock once.
  task automatic cyc(input logic rst, input logic rw, input logic m2r, input logic [31:0] rd,
                     input logic [31:0] alu, input logic [4:0] wr, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] dbg, input bit check);
    logic [31:0] e_wb, e_rs, e_rt, e_dbg;
    reset = rst; RegWrite_in = rw; MemToReg_in = m2r; read_data_in = rd;
    alu_result_in = alu; write_reg_in = wr; rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
    #2;
    e_wb  = m2r ? rd : alu;
    e_rs  = (rs == 0) ? 32'h0 : (rw && !rst && wr == rs) ? e_wb : model[rs];
    e_rt  = (rt == 0) ? 32'h0 : (rw && !rst && wr == rt) ? e_wb : model[rt];
    e_dbg = (dbg == 0) ? 32'h0 : model[dbg];
    if (check) begin
      chk("wb_data",   wb_data,  e_wb);
      chk("rs_data",   rs_data,  e_rs);
      chk("rt_data",   rt_data,  e_rt);
      chk("dbg_data",  dbg_data, e_dbg);
      chk("wb_count",  wb_count, cnt);
      chk("wb_count4", {28'h0, wb_count4}, cnt % 16);
    end
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
      cnt = 0;
    end else if (rw && wr != 0) begin
      model[wr] = e_wb;
      cnt++;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, rs, rt, dbg, 1'b1);
  endtask

  initial begin
    logic [4:0]  wr, rs, rt;
    foreach (model[i]) model[i] = 32'h0;
    cnt = 0;
    // reset: storage starts unknown, so the first reset cycle is not checked
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4, 5'd1, 1'b1);
    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a), 5'(a));
    chk("reset_count", wb_count, 32'h0);

    // ALU writeback with same-cycle bypass
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0, 5'd5, 1'b1);
    idle(5'd0, 5'd0, 5'd5);
    chk("alu_dbg5", dbg_data, 32'hDEADBEEF);
    chk("alu_cnt",  wb_count, 32'd1);

    // load writeback, both ports bypassing the same index
    cyc(1'b0, 1'b1, 1'b1, 32'h12345678, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 5'd31, 1'b1);
    idle(5'd31, 5'd0, 5'd31);
    chk("load_dbg31", dbg_data, 32'h12345678);

    // write to r0 is dropped, including through the bypass
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'hAAAA5555, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(5'd0, 5'd0, 5'd0);
    chk("r0_cnt", wb_count, 32'd2);

    // bubble: no write, no bypass
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b1);
    idle(5'd5, 5'd0, 5'd5);
    chk("bubble_r5", rs_data, 32'hDEADBEEF);

    // two ports bypassing different sources in one cycle: rt hits bypass, rs reads storage
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 5'd9, 5'd31, 5'd9, 5'd9, 1'b1);

    // reset beats a concurrent write
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 5'd7, 5'd7, 5'd7, 1'b1);
    idle(5'd7, 5'd31, 5'd7);
    chk("rst_r7",  dbg_data, 32'h0);
    chk("rst_cnt", wb_count, 32'h0);

    // 17 commits carry the 4-bit counter through its wrap
    for (int i = 0; i < 17; i++)
      cyc(1'b0, 1'b1, 1'b0, 32'h0, $urandom, 5'(1 + i % 31), 5'd1, 5'd2, 5'd3, 1'b1);
    idle(5'd0, 5'd0, 5'd0);
    chk("wrap4", {28'h0, wb_count4}, 32'd1);

    // random traffic, biased toward bypass hits
    for (int i = 0; i < 400; i++) begin
      wr = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 1) == 1) ? wr : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          $urandom, $urandom, wr, rs, rt, 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
